csr_arbiter: RTL and testbench

Round-robin arbiter that shares the CPLD's single 5-bit-address / 8-bit-data CSR bus between several bus masters, such as the board-management I2C slave bridge and a debug/SPI bridge. It serialises their accesses onto csr_a/csr_di/csr_we, which feed all register blocks including the interrupt controller. It returns the read data and a one-cycle acknowledge to the winning master. It sits between the bridges and the CSR slave fabric; slaves stay unaware of multiple masters.

---
 rtl/csr_arbiter_pkg.sv | 14 +
 rtl/csr_rr_pick.sv | 33 +++
 rtl/csr_arbiter.sv | 96 +++++++++
 tb/tb_csr_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_arbiter_pkg.sv
// Shared CSR bus widths and arbiter state encoding for csr_arbiter and its
// helpers.
package csr_arbiter_pkg;

    localparam int CSR_AW = 5;
    localparam int CSR_DW = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/csr_rr_pick.sv
// Combinational round-robin priority encoder: the search starts at
// last_grant+1 and wraps modulo N. Reusable by any arbiter.
module csr_rr_pick #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    output logic [N-1:0]  grant_oh,
    output logic [IW-1:0] grant_idx,
    output logic          valid
);

    int   idx_s;
    logic hit_s;

    // Walk the candidates in rotated order; the first requester found wins.
    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        valid     = 1'b0;
        idx_s     = 0;
        hit_s     = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx_s           = (int'(last_grant) + k) % N;
            hit_s           = ~valid & req[idx_s];
            grant_oh[idx_s] = hit_s;
            grant_idx       = hit_s ? IW'(idx_s) : grant_idx;
            valid           = valid | hit_s;
        end
    end

endmodule

// File: rtl/csr_arbiter.sv
// Round-robin arbiter that serialises several bus masters onto the shared
// 5-bit address / 8-bit data CSR bus and returns read data plus an ack.
module csr_arbiter
    import csr_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_MASTERS-1:0]      m_req,
    input  logic [NUM_MASTERS-1:0]      m_we,
    input  logic [CSR_AW*NUM_MASTERS-1:0] m_a,
    input  logic [CSR_DW*NUM_MASTERS-1:0] m_di,
    output logic [NUM_MASTERS-1:0]      m_ack,
    output logic [CSR_DW-1:0]           m_do,
    output logic [CSR_AW-1:0]           csr_a,
    output logic [CSR_DW-1:0]           csr_di,
    output logic                        csr_we,
    input  logic [CSR_DW-1:0]           csr_do
);

    localparam int IW = $clog2(NUM_MASTERS);

    arb_state_t             state_r;
    arb_state_t             state_s;
    logic [IW-1:0]          last_grant_r;
    logic [NUM_MASTERS-1:0] grant_oh_r;
    logic [NUM_MASTERS-1:0] pick_oh_s;
    logic [IW-1:0]          pick_idx_s;
    logic                   pick_valid_s;

    csr_rr_pick #(
        .N  (NUM_MASTERS),
        .IW (IW)
    ) u_pick (
        .req        (m_req),
        .last_grant (last_grant_r),
        .grant_oh   (pick_oh_s),
        .grant_idx  (pick_idx_s),
        .valid      (pick_valid_s)
    );

    // Next-state logic: every access takes exactly IDLE -> ACCESS -> DONE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (pick_valid_s) begin
                    state_s = ACCESS;
                end else begin
                    state_s = IDLE;
                end
            end
            ACCESS:  state_s = DONE;
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State, bus latches and master-side responses; csr_we self-clears so
    // it can only be high in the single ACCESS cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            last_grant_r <= IW'(NUM_MASTERS - 1);
            grant_oh_r   <= '0;
            csr_a        <= '0;
            csr_di       <= '0;
            csr_we       <= 1'b0;
            m_ack        <= '0;
            m_do         <= '0;
        end else begin
            state_r <= state_s;
            m_ack   <= '0;
            csr_we  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (pick_valid_s) begin
                        csr_a        <= m_a[int'(pick_idx_s)*CSR_AW +: CSR_AW];
                        csr_di       <= m_di[int'(pick_idx_s)*CSR_DW +: CSR_DW];
                        csr_we       <= m_we[pick_idx_s];
                        grant_oh_r   <= pick_oh_s;
                        last_grant_r <= pick_idx_s;
                    end
                end
                ACCESS: begin
                    m_do  <= csr_do;
                    m_ack <= grant_oh_r;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csr_arbiter.sv
// Self-checking bench for csr_arbiter: directed scenarios followed by random
// traffic, compared cycle by cycle against a transaction-level model.
module tb_csr_arbiter;

    localparam int N = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         preload;
    logic [N-1:0] m_req;
    logic [N-1:0] m_we;
    logic [5*N-1:0] m_a;
    logic [8*N-1:0] m_di;
    logic [N-1:0] m_ack;
    logic [7:0]   m_do;
    logic [4:0]   csr_a;
    logic [7:0]   csr_di;
    logic         csr_we;
    logic [7:0]   csr_do;

    int checks   = 0;
    int failures = 0;

    csr_arbiter #(.NUM_MASTERS(N)) dut (
        .clk    (clk),
        .rst    (rst),
        .m_req  (m_req),
        .m_we   (m_we),
        .m_a    (m_a),
        .m_di   (m_di),
        .m_ack  (m_ack),
        .m_do   (m_do),
        .csr_a  (csr_a),
        .csr_di (csr_di),
        .csr_we (csr_we),
        .csr_do (csr_do)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_val(input int i);
        return (i == 17) ? 8'h3C : 8'(i * 37 + 5);
    endfunction

    // Slave register file on the shared bus; it does not see rst.
    logic [7:0] smem [32];
    assign csr_do = smem[csr_a];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) smem[i] <= init_val(i);
        end else if (csr_we) begin
            smem[csr_a] <= csr_di;
        end
    end

    // Reference model: which transaction is in flight and what it implies.
    int         phase;      // 0 free, 1 bus driven, 2 acknowledging
    int         cur;
    int         lastg;
    logic [4:0] ea;
    logic [7:0] edi;
    logic       ewe;
    logic [N-1:0] eack;
    logic [7:0] edo;
    logic [7:0] mm [32];

    int rem [N];
    bit random_mode = 1'b0;
    int cyc = 0;
    int ack_cnt [N];
    int we_cnt = 0;
    int ack_order [$];
    int ack_time [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit found;
        eack = '0;
        if (rst) begin
            if (phase == 1 && ewe) mm[ea] = edi;
            phase = 0; lastg = N - 1;
            ea = '0; edi = '0; ewe = 1'b0; edo = '0;
        end else if (phase == 0) begin
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
                int i;
                i = (lastg + k) % N;
                if (!found && m_req[i]) begin
                    found = 1'b1;
                    cur = i;
                end
            end
            if (found) begin
                lastg = cur;
                ea    = m_a[cur*5 +: 5];
                edi   = m_di[cur*8 +: 8];
                ewe   = m_we[cur];
                phase = 1;
            end else begin
                ewe = 1'b0;
            end
        end else if (phase == 1) begin
            edo = mm[ea];
            if (ewe) mm[ea] = edi;
            ewe = 1'b0;
            eack[cur] = 1'b1;
            phase = 2;
        end else begin
            phase = 0;
        end
    endtask

    task automatic new_payload(input int i);
        m_we[i]       = 1'($urandom_range(0, 1));
        m_a[i*5 +: 5] = 5'($urandom_range(0, 31));
        m_di[i*8 +: 8] = 8'($urandom_range(0, 255));
    endtask

    task automatic cyc_step();
        @(posedge clk);
        #1;
        cyc++;
        model_edge();
        chk("csr_we", 32'(csr_we), 32'(ewe));
        chk("m_ack",  32'(m_ack),  32'(eack));
        chk("csr_a",  32'(csr_a),  32'(ea));
        chk("csr_di", 32'(csr_di), 32'(edi));
        chk("m_do",   32'(m_do),   32'(edo));
        if (csr_we) we_cnt++;
        for (int i = 0; i < N; i++) begin
            if (m_ack[i]) begin
                ack_cnt[i]++;
                ack_order.push_back(i);
                ack_time.push_back(cyc);
            end
        end
        // Masters: after an ack either issue a follow-up request or drop.
        for (int i = 0; i < N; i++) begin
            if (eack[i]) begin
                if (rem[i] > 0) begin
                    rem[i]--;
                    new_payload(i);
                end else begin
                    m_req[i] = 1'b0;
                end
            end
            if (random_mode && !m_req[i] && $urandom_range(0, 3) == 0) begin
                m_req[i] = 1'b1;
                rem[i]   = $urandom_range(0, 1);
                new_payload(i);
            end
        end
    endtask

    task automatic clear_stats();
        for (int i = 0; i < N; i++) ack_cnt[i] = 0;
        we_cnt = 0;
        ack_order.delete();
        ack_time.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc_step();
        cyc_step();
        rst = 1'b0;
        preload = 1'b0;
    endtask

    initial begin
        rst = 1'b1; preload = 1'b1;
        m_req = '0; m_we = '0; m_a = '0; m_di = '0;
        phase = 0; cur = 0; lastg = N - 1;
        ea = '0; edi = '0; ewe = 1'b0; eack = '0; edo = '0;
        for (int i = 0; i < 32; i++) mm[i] = init_val(i);
        for (int i = 0; i < N; i++) rem[i] = 0;
        clear_stats();

        do_reset();
        chk("rst_csr_we", 32'(csr_we), 32'd0);
        chk("rst_m_ack", 32'(m_ack), 32'd0);
        chk("rst_m_do", 32'(m_do), 32'd0);

        // Single write from master 0
        clear_stats();
        m_req[0] = 1'b1; m_we[0] = 1'b1; m_a[4:0] = 5'h10; m_di[7:0] = 8'hA5;
        cyc_step();
        chk("wr_csr_a", 32'(csr_a), 32'h10);
        chk("wr_csr_di", 32'(csr_di), 32'hA5);
        chk("wr_csr_we", 32'(csr_we), 32'd1);
        cyc_step();
        chk("wr_ack", 32'(m_ack), 32'd1);
        cyc_step();
        cyc_step();
        chk("wr_ack0_cnt", 32'(ack_cnt[0]), 32'd1);
        chk("wr_ack1_cnt", 32'(ack_cnt[1]), 32'd0);
        chk("wr_we_cnt", 32'(we_cnt), 32'd1);

        // Single read from master 1
        clear_stats();
        m_req[1] = 1'b1; m_we[1] = 1'b0; m_a[9:5] = 5'h11; m_di[15:8] = 8'h00;
        cyc_step();
        cyc_step();
        chk("rd_ack", 32'(m_ack), 32'd2);
        chk("rd_m_do", 32'(m_do), 32'h3C);
        cyc_step();
        chk("rd_we_cnt", 32'(we_cnt), 32'd0);

        // Contention from reset, both held for two transactions each
        do_reset();
        clear_stats();
        m_req = 2'b11; rem[0] = 1; rem[1] = 1;
        new_payload(0); new_payload(1);
        for (int s = 0; s < 14; s++) cyc_step();
        chk("cont_count", 32'(ack_order.size()), 32'd4);
        for (int s = 0; s < 4 && s < ack_order.size(); s++)
            chk("cont_order", 32'(ack_order[s]), 32'(s % 2));

        // Held request on master 0 for three transactions
        clear_stats();
        m_req[0] = 1'b1; rem[0] = 2; new_payload(0);
        for (int s = 0; s < 11; s++) cyc_step();
        chk("held_ack0", 32'(ack_cnt[0]), 32'd3);
        if (ack_time.size() == 3) begin
            chk("held_gap1", 32'(ack_time[1] - ack_time[0]), 32'd3);
            chk("held_gap2", 32'(ack_time[2] - ack_time[1]), 32'd3);
        end else begin
            chk("held_ack_times", 32'(ack_time.size()), 32'd3);
        end

        // Reset during the ACCESS cycle of a write
        clear_stats();
        m_req[0] = 1'b1; m_we[0] = 1'b1; m_a[4:0] = 5'h03; m_di[7:0] = 8'h77;
        cyc_step();
        chk("rstacc_we", 32'(csr_we), 32'd1);
        rst = 1'b1;
        cyc_step();
        rst = 1'b0;
        chk("rstacc_we_after", 32'(csr_we), 32'd0);
        chk("rstacc_no_ack", 32'(m_ack), 32'd0);
        for (int s = 0; s < 3; s++) cyc_step();
        chk("rstacc_fresh_ack", 32'(ack_cnt[0]), 32'd1);

        // Early drop by master 1
        clear_stats();
        m_req[1] = 1'b1; m_we[1] = 1'b1; m_a[9:5] = 5'h07; m_di[15:8] = 8'h5A;
        cyc_step();
        m_req[1] = 1'b0;
        for (int s = 0; s < 5; s++) cyc_step();
        chk("drop_ack1", 32'(ack_cnt[1]), 32'd1);
        chk("drop_we_cnt", 32'(we_cnt), 32'd1);

        // Random traffic
        random_mode = 1'b1;
        for (int s = 0; s < 600; s++) cyc_step();
        random_mode = 1'b0;
        m_req = '0;
        for (int s = 0; s < 4; s++) cyc_step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
